pueo_time_tx: RTL

Serial timestamp transmitter. It is the sending end of the PPS/second-count path in the time subsystem. On every accepted PPS flag it latches the second value that the time core's second counter takes next. It then shifts that value out as a framed, checksummed, single-bit message so downstream boards can align their own second counters. It runs in the system clock domain, directly beside the time wrapper, and consumes its `pps_flag_o` and `cur_sec_o`.

---
 rtl/pueo_time_tx_pkg.sv | 12 +
 rtl/pueo_time_tx_if.sv | 19 +
 rtl/pueo_time_tx_baud.sv | 18 +
 rtl/pueo_time_tx.sv | 66 ++++++
 4 files changed

// File: rtl/pueo_time_tx_pkg.sv
// pueo_time_tx_pkg: frame geometry, default sync word, FSM state type and checksum helper
package pueo_time_tx_pkg;
  localparam int FRAME_BITS = 48;
  localparam int SYNC_BITS = 8;
  localparam int SEC_BITS = 32;
  localparam int CKSUM_BITS = 8;
  localparam logic [SYNC_BITS-1:0] DEF_SYNC_WORD = 8'hB5;
  typedef enum logic [2:0] {IDLE, SYNC, SEC, CKSUM, STOP} time_tx_state_t;
  function automatic logic [CKSUM_BITS-1:0] sec_cksum(input logic [SEC_BITS-1:0] s);
    return s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
  endfunction
endpackage

// File: rtl/pueo_time_tx_if.sv
// pueo_time_tx_if: timestamp tx bus; master drives en/pps/cur_sec/overrun_clr, slave drives tx/busy/sent/overrun
interface pueo_time_tx_if;
  logic en_i;
  logic pps_flag_i;
  logic [31:0] cur_sec_i;
  logic overrun_clr_i;
  logic tx_o;
  logic busy_o;
  logic sent_o;
  logic overrun_o;
  modport master (
    output en_i, pps_flag_i, cur_sec_i, overrun_clr_i,
    input  tx_o, busy_o, sent_o, overrun_o
  );
  modport slave (
    input  en_i, pps_flag_i, cur_sec_i, overrun_clr_i,
    output tx_o, busy_o, sent_o, overrun_o
  );
endinterface

// File: rtl/pueo_time_tx_baud.sv
// pueo_time_tx_baud: bit-period down-counter (clk, async rst, sync restart) -> tick on last cycle of each bit, pre one cycle earlier
module pueo_time_tx_baud #(
  parameter int BIT_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic pre
);
  localparam int W = $clog2(BIT_DIV);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (restart || cnt == '0) ? W'(BIT_DIV - 1) : cnt - 1'b1;
  assign tick = cnt == '0;
  assign pre = cnt == W'(1);
endmodule

// File: rtl/pueo_time_tx.sv
// pueo_time_tx: PPS-latched second-count serial framer; ports sys_clk_i, sys_rst_i (async high), bus (slave: en/pps/cur_sec/overrun_clr in, tx/busy/sent/overrun out)
module pueo_time_tx
  import pueo_time_tx_pkg::*;
#(
  parameter int BIT_DIV = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input logic sys_clk_i,
  input logic sys_rst_i,
  pueo_time_tx_if.slave bus
);
  localparam logic [5:0] SYNC_END = 6'(SYNC_BITS - 1);
  localparam logic [5:0] SEC_END = 6'(SYNC_BITS + SEC_BITS - 1);
  localparam logic [5:0] CKSUM_END = 6'(FRAME_BITS - 1);
  time_tx_state_t state, nstate;
  logic [FRAME_BITS-1:0] sr;
  logic [5:0] idx;
  logic [SEC_BITS-1:0] sec;
  logic accept, tick, pre, busy, sent, ovr;
  assign accept = bus.pps_flag_i && bus.en_i && state == IDLE;
  assign sec = bus.cur_sec_i + 32'd1;
  pueo_time_tx_baud #(.BIT_DIV(BIT_DIV)) u_baud (
    .clk(sys_clk_i),
    .rst(sys_rst_i),
    .restart(accept),
    .tick(tick),
    .pre(pre)
  );
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  nstate = accept ? SYNC : IDLE;
      SYNC:  nstate = (tick && idx == SYNC_END) ? SEC : SYNC;
      SEC:   nstate = (tick && idx == SEC_END) ? CKSUM : SEC;
      CKSUM: nstate = (tick && idx == CKSUM_END) ? STOP : CKSUM;
      STOP:  nstate = tick ? IDLE : STOP;
      default: nstate = IDLE;
    endcase
  end
  // shifting in zeros leaves the line low through STOP and IDLE, so tx is simply the register MSB
  always_ff @(posedge sys_clk_i or posedge sys_rst_i)
    if (sys_rst_i) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      busy <= 1'b0;
      sent <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= nstate;
      busy <= nstate != IDLE;
      sent <= state == STOP && pre;
      ovr <= (bus.pps_flag_i && state != IDLE) ? 1'b1 : bus.overrun_clr_i ? 1'b0 : ovr;
      if (accept) begin
        sr <= {SYNC_WORD, sec, sec_cksum(sec)};
        idx <= '0;
      end else if (tick && state != IDLE) begin
        sr <= {sr[FRAME_BITS-2:0], 1'b0};
        idx <= idx + 6'd1;
      end
    end
  assign bus.tx_o = sr[FRAME_BITS-1];
  assign bus.busy_o = busy;
  assign bus.sent_o = sent;
  assign bus.overrun_o = ovr;
endmodule
